// File: rtl/id_ex_alu_feed_if.sv
// id_ex_alu_feed_if: decode-in / ALU-out handshake bundle for the ID/EX stage.
interface id_ex_alu_feed_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_inst;
  logic [31:0] in_rs_val;
  logic [31:0] in_rt_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_alu_a;
  logic [31:0] out_alu_b;
  logic [3:0]  out_aluop;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic        out_illegal;
  modport master (
    output in_valid, in_pc, in_inst, in_rs_val, in_rt_val, out_ready,
    input  in_ready, out_valid, out_pc, out_alu_a, out_alu_b, out_aluop, out_dest, out_wen, out_illegal
  );
  modport slave (
    input  in_valid, in_pc, in_inst, in_rs_val, in_rt_val, out_ready,
    output in_ready, out_valid, out_pc, out_alu_a, out_alu_b, out_aluop, out_dest, out_wen, out_illegal
  );
endinterface

// File: rtl/id_ex_alu_feed.sv
// id_ex_alu_feed: decodes MIPS ALU instructions into ALUop/operands held in a single-entry valid/ready register.
module id_ex_alu_feed (
  input logic             clk,
  input logic             resetn,
  input logic             flush,
  id_ex_alu_feed_if.slave bus
);
  localparam logic [3:0] OP_AND = 4'b0000, OP_OR = 4'b0001, OP_ADD = 4'b0010, OP_SLL = 4'b0011;
  localparam logic [3:0] OP_SLTU = 4'b0100, OP_LUI = 4'b0101, OP_SUB = 4'b0110, OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1000, OP_XOR = 4'b1001, OP_SLLV = 4'b1010, OP_SRL = 4'b1011;
  localparam logic [3:0] OP_SRLV = 4'b1100, OP_SRA = 4'b1101, OP_SRAV = 4'b1110;
  logic [5:0]  opc, fn;
  logic [15:0] imm;
  logic        legal, sh_imm, use_imm, zext, load;
  logic [3:0]  aluop;
  logic [4:0]  dest;
  logic [31:0] ext, a, b;
  logic        valid_q, valid_d, wen_q, wen_d, ill_q;
  logic [31:0] pc_q, a_q, b_q;
  logic [3:0]  op_q;
  logic [4:0]  dest_q;
  assign opc = bus.in_inst[31:26];
  assign fn  = bus.in_inst[5:0];
  assign imm = bus.in_inst[15:0];
  always_comb begin
    legal   = 1'b1;
    sh_imm  = 1'b0;
    use_imm = 1'b1;
    zext    = 1'b0;
    aluop   = OP_AND;
    dest    = bus.in_inst[20:16];
    if (opc == 6'h00) begin
      use_imm = 1'b0;
      dest    = bus.in_inst[15:11];
      case (fn)
        6'h20, 6'h21: aluop = OP_ADD;
        6'h22, 6'h23: aluop = OP_SUB;
        6'h24: aluop = OP_AND;
        6'h25: aluop = OP_OR;
        6'h26: aluop = OP_XOR;
        6'h27: aluop = OP_NOR;
        6'h2a: aluop = OP_SLT;
        6'h2b: aluop = OP_SLTU;
        6'h00: begin aluop = OP_SLL; sh_imm = 1'b1; end
        6'h02: begin aluop = OP_SRL; sh_imm = 1'b1; end
        6'h03: begin aluop = OP_SRA; sh_imm = 1'b1; end
        6'h04: aluop = OP_SLLV;
        6'h06: aluop = OP_SRLV;
        6'h07: aluop = OP_SRAV;
        default: legal = 1'b0;
      endcase
    end else begin
      case (opc)
        6'h09: aluop = OP_ADD;
        6'h0a: aluop = OP_SLT;
        6'h0b: aluop = OP_SLTU;
        6'h0c: begin aluop = OP_AND; zext = 1'b1; end
        6'h0d: begin aluop = OP_OR;  zext = 1'b1; end
        6'h0e: begin aluop = OP_XOR; zext = 1'b1; end
        6'h0f: begin aluop = OP_LUI; zext = 1'b1; end
        default: legal = 1'b0;
      endcase
    end
  end
  // the ALU expects the immediate shift amount pre-positioned at A[10:6]
  assign ext  = zext ? {16'b0, imm} : {{16{imm[15]}}, imm};
  assign a    = !legal ? 32'b0 : sh_imm ? {21'b0, bus.in_inst[10:6], 6'b0} : bus.in_rs_val;
  assign b    = !legal ? 32'b0 : use_imm ? ext : bus.in_rt_val;
  assign bus.in_ready = ~valid_q | bus.out_ready;
  assign load    = bus.in_valid & bus.in_ready & ~flush;
  assign valid_d = flush ? 1'b0 : load ? 1'b1 : bus.out_ready ? 1'b0 : valid_q;
  assign wen_d   = flush ? 1'b0 : load ? (legal && dest != 5'd0) : wen_q;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      wen_q   <= 1'b0;
      ill_q   <= 1'b0;
      pc_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      dest_q  <= '0;
    end else begin
      valid_q <= valid_d;
      wen_q   <= wen_d;
      if (load) begin
        ill_q  <= ~legal;
        pc_q   <= bus.in_pc;
        a_q    <= a;
        b_q    <= b;
        op_q   <= aluop;
        dest_q <= dest;
      end
    end
  end
  assign bus.out_valid   = valid_q;
  assign bus.out_pc      = pc_q;
  assign bus.out_alu_a   = a_q;
  assign bus.out_alu_b   = b_q;
  assign bus.out_aluop   = op_q;
  assign bus.out_dest    = dest_q;
  assign bus.out_wen     = wen_q;
  assign bus.out_illegal = ill_q;
endmodule

// File: tb/tb_id_ex_alu_feed.sv
// tb_id_ex_alu_feed: directed vectors with a scoreboard queue checked by a monitor on consumed outputs.
module tb_id_ex_alu_feed;
  logic clk = 1'b0, resetn = 1'b0, flush = 1'b0;
  id_ex_alu_feed_if bus ();
  id_ex_alu_feed dut (.clk(clk), .resetn(resetn), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] pc, a, b;
    logic [3:0]  op;
    logic [4:0]  dest;
    logic        wen, ill;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  logic [31:0] pc = 32'h100;
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", n, act, exp);
    end
  endtask
  function automatic exp_t mk(logic [31:0] a, logic [31:0] b, logic [3:0] op, logic [4:0] d, logic w, logic il);
    exp_t e;
    e.pc = 32'h0; e.a = a; e.b = b; e.op = op; e.dest = d; e.wen = w; e.ill = il;
    return e;
  endfunction
  always @(negedge clk) begin
    if (resetn && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pc", bus.out_pc, e.pc);
        chk("alu_a", bus.out_alu_a, e.a);
        chk("alu_b", bus.out_alu_b, e.b);
        chk("aluop", {28'b0, bus.out_aluop}, {28'b0, e.op});
        if (!e.ill) chk("dest", {27'b0, bus.out_dest}, {27'b0, e.dest});
        chk("wen", {31'b0, bus.out_wen}, {31'b0, e.wen});
        chk("illegal", {31'b0, bus.out_illegal}, {31'b0, e.ill});
      end
    end
  end
  task automatic send(logic [31:0] inst, logic [31:0] rs, logic [31:0] rt, bit push, exp_t e);
    int n;
    bus.in_valid = 1'b1; bus.in_inst = inst; bus.in_rs_val = rs; bus.in_rt_val = rt; bus.in_pc = pc;
    if (push) begin e.pc = pc; q.push_back(e); end
    pc += 4;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.in_ready && n < 20);
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic chk_reset_vals(string n);
    chk({n, "_valid"}, {31'b0, bus.out_valid}, 32'd0);
    chk({n, "_pc"}, bus.out_pc, 32'd0);
    chk({n, "_a"}, bus.out_alu_a, 32'd0);
    chk({n, "_b"}, bus.out_alu_b, 32'd0);
    chk({n, "_aluop"}, {28'b0, bus.out_aluop}, 32'd0);
    chk({n, "_dest"}, {27'b0, bus.out_dest}, 32'd0);
    chk({n, "_wen"}, {31'b0, bus.out_wen}, 32'd0);
    chk({n, "_illegal"}, {31'b0, bus.out_illegal}, 32'd0);
  endtask
  initial begin
    exp_t e;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.in_rs_val = '0; bus.in_rt_val = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    send(32'h00021940, 32'hDEADBEEF, 32'h3, 1, mk(32'h140, 32'h3, 4'h3, 5'd3, 1, 0));
    send(32'h2424FFFF, 32'h10, 32'h0, 1, mk(32'h10, 32'hFFFFFFFF, 4'h2, 5'd4, 1, 0));
    send(32'h3424FFFF, 32'h10, 32'h0, 1, mk(32'h10, 32'h0000FFFF, 4'h1, 5'd4, 1, 0));
    send(32'h3C051234, 32'h0, 32'h0, 1, mk(32'h0, 32'h00001234, 4'h5, 5'd5, 1, 0));
    send(32'h00220021, 32'h5, 32'h7, 1, mk(32'h5, 32'h7, 4'h2, 5'd0, 0, 0));
    send(32'hFC000000, 32'h5, 32'h7, 1, mk(32'h0, 32'h0, 4'h0, 5'd0, 0, 1));
    send(32'h00000001, 32'h5, 32'h7, 1, mk(32'h0, 32'h0, 4'h0, 5'd0, 0, 1));
    send(32'h00E83023, 32'h64, 32'h14, 1, mk(32'h64, 32'h14, 4'h6, 5'd6, 1, 0));
    send(32'h016A4807, 32'h4, 32'h80000000, 1, mk(32'h4, 32'h80000000, 4'hE, 5'd9, 1, 0));
    send(32'h2862FFFB, 32'h3, 32'h0, 1, mk(32'h3, 32'hFFFFFFFB, 4'h7, 5'd2, 1, 0));
    send(32'h00020FC3, 32'h0, 32'h80000000, 1, mk(32'h7C0, 32'h80000000, 4'hD, 5'd1, 1, 0));
    send(32'h30E78001, 32'hFFFFFFFF, 32'h0, 1, mk(32'hFFFFFFFF, 32'h00008001, 4'h0, 5'd7, 1, 0));
    repeat (3) @(posedge clk); #1;
    // backpressure: ADDU held for three stalled cycles, then XOR replaces it without a bubble
    bus.out_ready = 1'b0;
    send(32'h00221821, 32'h11, 32'h22, 1, mk(32'h11, 32'h22, 4'h2, 5'd3, 1, 0));
    bus.in_valid = 1'b1; bus.in_inst = 32'h00222026; bus.in_rs_val = 32'hF0F0; bus.in_rt_val = 32'h0FF0; bus.in_pc = pc;
    e = mk(32'hF0F0, 32'h0FF0, 4'h9, 5'd4, 1, 0);
    e.pc = pc;
    pc += 4;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_a", bus.out_alu_a, 32'h11);
      chk("stall_b", bus.out_alu_b, 32'h22);
      chk("stall_dest", {27'b0, bus.out_dest}, 32'd3);
    end
    q.push_back(e);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("no_bubble_valid", {31'b0, bus.out_valid}, 32'd1);
    @(posedge clk); #1;
    // flush kills the held entry and the same-cycle input
    bus.out_ready = 1'b0;
    send(32'h3424FFFF, 32'h1, 32'h0, 0, e);
    bus.in_valid = 1'b1; bus.in_inst = 32'h2424FFFF; bus.in_pc = pc;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_wen", {31'b0, bus.out_wen}, 32'd0);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clk);
    chk("flush_not_captured", {31'b0, bus.out_valid}, 32'd0);
    @(posedge clk); #1;
    // asynchronous reset during a stall
    send(32'h2424FFFF, 32'h10, 32'h0, 0, e);
    @(negedge clk);
    chk("pre_areset_valid", {31'b0, bus.out_valid}, 32'd1);
    #2 resetn = 1'b0;
    #1 chk_reset_vals("areset");
    @(posedge clk); #1;
    resetn = 1'b1;
    bus.out_ready = 1'b1;
    send(32'h3C051234, 32'h0, 32'h0, 1, mk(32'h0, 32'h00001234, 4'h5, 5'd5, 1, 0));
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
